sd_data_xfer_sched: RTL and testbench
=====================================

Name: sd_data_xfer_sched

Overview:
- Multi-block transfer sequencer for the SD data serial host.
- Accepts a write or read request for N blocks.
- Per block: gates the start on FIFO readiness, pulses start_dat, tracks host busy_n/transm_complete, and samples crc_ok.
- Hand-shakes block release via ack_transfer, aborts on timeout, and reports done/error status to the register/DMA layer.
- Sits between the controller register block and the data serial host, in the sd_clk domain.

Parameters:
- BLK_CNT_W, 8, width of block count and remaining-block counter.
- TO_W, 16, width of per-block timeout counter.
- RETRY_MAX, 2, max re-sends of one block after CRC failure (used only with retry feature).
- ACK_GAP, 3, idle cycles after ack_transfer drop before next start. Covers the host's 2-flop ack synchroniser.

Ports:
- sd_clk  in  1  SD-side clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_write  in  1  1-cycle pulse, start multi-block write.
- req_read  in  1  1-cycle pulse, start multi-block read.
- blk_count  in  BLK_CNT_W  blocks to transfer, sampled on accepted request.
- timeout_val  in  TO_W  per-block cycle limit; 0 disables timeout.
- tx_ready  in  1  TX FIFO holds at least one block-start worth of data.
- rx_ready  in  1  RX FIFO has room for one block.
- busy_n  in  1  from host; 0 while host is out of IDLE.
- transm_complete  in  1  from host; block finished.
- crc_ok  in  1  from host; valid when transm_complete=1.
- start_dat  out  2  to host: 01 write, 10 read, 11 abort, 00 none.
- ack_transfer  out  1  to host: releases WRITE_BUSY/READ_DAT.
- xfer_busy  out  1  sequence in progress.
- xfer_done  out  1  1-cycle pulse at end of sequence (success or error).
- err_crc  out  1  sticky CRC failure, cleared on next accepted request.
- err_timeout  out  1  sticky timeout, cleared on next accepted request.
- blk_remaining  out  BLK_CNT_W  blocks not yet completed.

Behaviour:
- Reset values: start_dat=00, ack_transfer=0, xfer_busy=0, xfer_done=0, err_crc=0, err_timeout=0, blk_remaining=0. FSM in IDLE; direction, timeout, gap and retry counters = 0.
- IDLE:
  - req_write has priority over req_read when both are set.
  - On an accepted request: latch direction, load blk_remaining=blk_count, clear both error flags, set xfer_busy=1.
  - blk_count=0: go to FINISH directly; host is never started.
  - Requests arriving while xfer_busy=1 are ignored.
- ARM: wait for tx_ready (write) or rx_ready (read), then go to START.
- START: drive start_dat=01/10 for exactly one cycle, then 00. Go to WAIT_BUSY.
- WAIT_BUSY:
  - busy_n=0 → XFER.
  - busy_n still 1 after 4 cycles → err_timeout=1, go to FINISH.
- XFER:
  - Timeout counter increments each cycle.
  - When transm_complete=1: sample crc_ok, go to ACK.
  - If timeout_val≠0 and counter==timeout_val-1 before completion → ABORT.
- ACK:
  - Hold ack_transfer=1 until busy_n=1 (host back in IDLE), then drop it and go to GAP.
  - Applies to both directions; covers write busy release and read CRC end.
- GAP: wait ACK_GAP cycles, then evaluate:
  - crc_ok=1: decrement blk_remaining. If it reaches 0 → FINISH, else → ARM.
  - crc_ok=0: err_crc=1 → FINISH (retry feature changes this).
- ABORT:
  - Drive start_dat=11 and ack_transfer=1 until busy_n=1, then set err_timeout=1 and go to FINISH.
  - If the host is stuck in READ_WAIT (no start bit), ABORT persists with xfer_busy=1; recovery is rst_n only.
- FINISH: pulse xfer_done for 1 cycle, set xfer_busy=0, return to IDLE. blk_remaining holds the count not completed.
- Counters: blk_remaining does not decrement below 0; the timeout counter saturates and resets on entry to XFER.
- rst_n asserted mid-transfer: all outputs go to reset values immediately (asynchronous); no abort is issued.

Optional Feature:
- Macro: SD_XFER_RETRY_EN.
- Defined: on crc_ok=0 in GAP, if retry_cnt<RETRY_MAX, increment retry_cnt and return to ARM with the same blk_remaining. Otherwise set err_crc and go to FINISH. retry_cnt clears on each successful block.
- Undefined: the first CRC failure sets err_crc and goes to FINISH; no retry counter is synthesised.

Test Plan:
1. req_write, blk_count=3, tx_ready=1, host model completes with crc_ok=1 → three start_dat=01 pulses, each at least ACK_GAP+1 cycles after ack_transfer falls; blk_remaining 3→2→1→0; one xfer_done pulse; no errors.
2. req_read, blk_count=1, rx_ready low for 10 cycles then high → start_dat=10 issued only after rx_ready=1; ack_transfer held until busy_n=1.
3. req_write and req_read in the same cycle, blk_count=2 → write performed; read ignored; a req_read during xfer_busy is ignored.
4. timeout_val=50, host never asserts transm_complete → start_dat=11 and ack_transfer=1 at cycle 50 of XFER until busy_n=1; err_timeout=1; xfer_done pulse; blk_remaining unchanged.
5. crc_ok=0 on block 2 of 4:
   - Without SD_XFER_RETRY_EN: err_crc=1, blk_remaining=3 at done.
   - With it (RETRY_MAX=2): block re-sent; if the retry passes, all 4 complete with no error.
6. rst_n pulsed low in XFER, then blk_count=0 request → all outputs reset; the zero-count request gives xfer_done in ≤2 cycles with start_dat never leaving 00.

Source files
------------

// File: rtl/sd_data_xfer_sched.sv
// sd_data_xfer_sched: multi-block SD data transfer sequencer driving the data serial host.
// Define SD_XFER_RETRY_EN to re-send a block after a CRC failure (up to RETRY_MAX times).
module sd_data_xfer_sched #(
    parameter int BLK_CNT_W = 8,
    parameter int TO_W      = 16,
    parameter int RETRY_MAX = 2,
    parameter int ACK_GAP   = 3
) (
    input  logic                 i_sd_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_write,
    input  logic                 i_req_read,
    input  logic [BLK_CNT_W-1:0] i_blk_count,
    input  logic [TO_W-1:0]      i_timeout_val,
    input  logic                 i_tx_ready,
    input  logic                 i_rx_ready,
    input  logic                 i_busy_n,
    input  logic                 i_transm_complete,
    input  logic                 i_crc_ok,
    output logic [1:0]           o_start_dat,
    output logic                 o_ack_transfer,
    output logic                 o_xfer_busy,
    output logic                 o_xfer_done,
    output logic                 o_err_crc,
    output logic                 o_err_timeout,
    output logic [BLK_CNT_W-1:0] o_blk_remaining
);
    localparam int GAP_W = $clog2(ACK_GAP + 1);
    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_START, S_WAIT_BUSY, S_XFER, S_ACK, S_GAP, S_ABORT, S_FINISH
    } state_t;
    state_t               r_state, w_state;
    logic                 r_dir, w_dir;
    logic [BLK_CNT_W-1:0] r_blk_rem, w_blk_rem;
    logic                 r_err_crc, w_err_crc;
    logic                 r_err_to, w_err_to;
    logic [TO_W-1:0]      r_to_cnt, w_to_cnt;
    logic [1:0]           r_wb_cnt, w_wb_cnt;
    logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt;
    logic                 r_crc, w_crc;
`ifdef SD_XFER_RETRY_EN
    localparam int RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0]        r_retry, w_retry;
`endif
    always_ff @(posedge i_sd_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_blk_rem <= '0;
            r_err_crc <= 1'b0;
            r_err_to  <= 1'b0;
            r_to_cnt  <= '0;
            r_wb_cnt  <= '0;
            r_gap_cnt <= '0;
            r_crc     <= 1'b0;
`ifdef SD_XFER_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_dir     <= w_dir;
            r_blk_rem <= w_blk_rem;
            r_err_crc <= w_err_crc;
            r_err_to  <= w_err_to;
            r_to_cnt  <= w_to_cnt;
            r_wb_cnt  <= w_wb_cnt;
            r_gap_cnt <= w_gap_cnt;
            r_crc     <= w_crc;
`ifdef SD_XFER_RETRY_EN
            r_retry   <= w_retry;
`endif
        end
    end
    always_comb begin
        w_state        = r_state;
        w_dir          = r_dir;
        w_blk_rem      = r_blk_rem;
        w_err_crc      = r_err_crc;
        w_err_to       = r_err_to;
        w_to_cnt       = r_to_cnt;
        w_wb_cnt       = r_wb_cnt;
        w_gap_cnt      = r_gap_cnt;
        w_crc          = r_crc;
`ifdef SD_XFER_RETRY_EN
        w_retry        = r_retry;
`endif
        o_start_dat    = 2'b00;
        o_ack_transfer = 1'b0;
        o_xfer_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_write || i_req_read) begin
                    w_dir     = !i_req_write;
                    w_blk_rem = i_blk_count;
                    w_err_crc = 1'b0;
                    w_err_to  = 1'b0;
`ifdef SD_XFER_RETRY_EN
                    w_retry   = '0;
`endif
                    w_state   = (i_blk_count == '0) ? S_FINISH : S_ARM;
                end
            end
            S_ARM: if (r_dir ? i_rx_ready : i_tx_ready) w_state = S_START;
            S_START: begin
                o_start_dat = r_dir ? 2'b10 : 2'b01;
                w_wb_cnt    = '0;
                w_state     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i_busy_n) begin
                    w_to_cnt = '0;
                    w_state  = S_XFER;
                end else if (r_wb_cnt == 2'd3) begin
                    w_err_to = 1'b1;
                    w_state  = S_FINISH;
                end else begin
                    w_wb_cnt = r_wb_cnt + 2'd1;
                end
            end
            S_XFER: begin
                if (i_transm_complete) begin
                    w_crc   = i_crc_ok;
                    w_state = S_ACK;
                end else if (i_timeout_val != '0 && r_to_cnt == i_timeout_val - TO_W'(1)) begin
                    w_state = S_ABORT;
                end else if (r_to_cnt != '1) begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                end
            end
            S_ACK: begin
                o_ack_transfer = 1'b1;
                if (i_busy_n) begin
                    w_gap_cnt = '0;
                    w_state   = S_GAP;
                end
            end
            // The gap lets the host's ack synchroniser see the drop before the next start.
            S_GAP: begin
                if (r_gap_cnt != GAP_W'(ACK_GAP - 1)) begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                end else if (r_crc) begin
                    w_blk_rem = (r_blk_rem != '0) ? r_blk_rem - BLK_CNT_W'(1) : r_blk_rem;
                    w_state   = (r_blk_rem <= BLK_CNT_W'(1)) ? S_FINISH : S_ARM;
`ifdef SD_XFER_RETRY_EN
                    w_retry   = '0;
                end else if (r_retry < RW'(RETRY_MAX)) begin
                    w_retry   = r_retry + RW'(1);
                    w_state   = S_ARM;
`endif
                end else begin
                    w_err_crc = 1'b1;
                    w_state   = S_FINISH;
                end
            end
            S_ABORT: begin
                o_start_dat    = 2'b11;
                o_ack_transfer = 1'b1;
                if (i_busy_n) begin
                    w_err_to = 1'b1;
                    w_state  = S_FINISH;
                end
            end
            S_FINISH: begin
                o_xfer_done = 1'b1;
                w_state     = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end
    assign o_xfer_busy     = (r_state != S_IDLE);
    assign o_err_crc       = r_err_crc;
    assign o_err_timeout   = r_err_to;
    assign o_blk_remaining = r_blk_rem;
endmodule

// File: tb/tb_sd_data_xfer_sched.sv
// tb_sd_data_xfer_sched: directed table, corner sequences and randomized runs against a host model.
// Compile with SD_XFER_RETRY_EN defined to exercise the retry build.
module tb_sd_data_xfer_sched;
    localparam int BW = 8;
    localparam int TW = 16;
    localparam int GAP = 3;
`ifdef SD_XFER_RETRY_EN
    localparam int RMAX = 2;
`else
    localparam int RMAX = 0;
`endif
    logic clk = 1'b0;
    logic rst_n, req_write, req_read, tx_ready, rx_ready, busy_n, tc, crc_ok;
    logic [BW-1:0] blk_count;
    logic [TW-1:0] timeout_val;
    logic [1:0] start_dat;
    logic ack, xbusy, xdone, ecrc, eto;
    logic [BW-1:0] rem;

    always #5 clk = ~clk;

    sd_data_xfer_sched #(.BLK_CNT_W(BW), .TO_W(TW), .RETRY_MAX(2), .ACK_GAP(GAP)) dut (
        .i_sd_clk(clk), .i_rst_n(rst_n), .i_req_write(req_write), .i_req_read(req_read),
        .i_blk_count(blk_count), .i_timeout_val(timeout_val), .i_tx_ready(tx_ready),
        .i_rx_ready(rx_ready), .i_busy_n(busy_n), .i_transm_complete(tc), .i_crc_ok(crc_ok),
        .o_start_dat(start_dat), .o_ack_transfer(ack), .o_xfer_busy(xbusy),
        .o_xfer_done(xdone), .o_err_crc(ecrc), .o_err_timeout(eto), .o_blk_remaining(rem));

    int total = 0, bad = 0;
    int h_lat = 2, h_ackd = 1, h_att0 = 0, h_att = 0, hs = 0, hc = 0;
    bit h_hang = 0, h_noresp = 0;
    logic [31:0] h_fail = '0;

    // Host model: per-attempt CRC outcome, programmable latency and ack release delay
    initial begin
        busy_n = 1'b1; tc = 1'b0; crc_ok = 1'b1;
        forever begin
            @(negedge clk);
            tc = 1'b0;
            if (!rst_n) begin
                busy_n = 1'b1; hs = 0;
            end else begin
                if (hs == 0 && (start_dat == 2'b01 || start_dat == 2'b10) && !h_noresp) begin
                    busy_n = 1'b0; hc = h_lat; hs = 1;
                end else if (hs == 1 && start_dat == 2'b11) begin
                    hc = h_ackd; hs = 3;
                end else if (hs == 1 && !h_hang) begin
                    if (hc == 0) begin
                        tc = 1'b1;
                        crc_ok = !((h_att - h_att0) < 32 && h_fail[h_att - h_att0]);
                        h_att++; hs = 2;
                    end else hc--;
                end else if (hs == 2 && ack) begin
                    hc = h_ackd; hs = 3;
                end
                if (hs == 3) begin
                    if (hc == 0) begin busy_n = 1'b1; hs = 0; end
                    else hc--;
                end
            end
        end
    end

    int cyc = 0, n_wr = 0, n_rd = 0, n_ab = 0, n_done = 0, n_any = 0;
    int t_start = 0, t_abort = 0, t_fall = -1000, min_gap = 1000, ack_len = 0, cur = 0;
    logic p_ack = 1'b0;
    logic [1:0] p_sd = 2'b00;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (start_dat != 2'b00) n_any++;
        if (start_dat == 2'b01 || start_dat == 2'b10) begin
            if (start_dat == 2'b01) n_wr++; else n_rd++;
            if (cyc - t_fall < min_gap) min_gap = cyc - t_fall;
            t_start = cyc;
        end
        if (start_dat == 2'b11 && p_sd != 2'b11) begin n_ab++; t_abort = cyc; end
        if (ack) cur++;
        else if (p_ack) begin ack_len = cur; cur = 0; t_fall = cyc; end
        if (xdone) n_done++;
        p_ack = ack; p_sd = start_dat;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    int b_wr, b_rd, b_ab, b_done, b_any;

    task automatic req(input bit wr, input bit rd, input int cnt);
        b_wr = n_wr; b_rd = n_rd; b_ab = n_ab; b_done = n_done; b_any = n_any; h_att0 = h_att;
        blk_count = cnt[BW-1:0]; req_write = wr; req_read = rd;
        tick(1);
        req_write = 1'b0; req_read = 1'b0;
    endtask

    task automatic wait_done(input bit poke, input bit rnd);
        int i = 0;
        while (n_done == b_done && i < 4000) begin
            if (rnd) begin
                tx_ready = ($urandom % 3) != 0;
                rx_ready = ($urandom % 3) != 0;
            end
            req_write = poke && i == 4;
            req_read  = poke && i == 4;
            tick(1);
            i++;
        end
        if (n_done == b_done) begin
            total++; bad++;
            $display("FAIL wait_done: no xfer_done within %0d cycles", i);
        end
        req_write = 1'b0; req_read = 1'b0; tx_ready = 1'b1; rx_ready = 1'b1;
        tick(1);
    endtask

    task automatic check_run(input string nm, input int e_rem, input int e_wr, input int e_rd,
                             input int e_crc, input int e_to);
        chk({nm, "_rem"}, int'(rem), e_rem);
        chk({nm, "_wr_starts"}, n_wr - b_wr, e_wr);
        chk({nm, "_rd_starts"}, n_rd - b_rd, e_rd);
        chk({nm, "_err_crc"}, int'(ecrc), e_crc);
        chk({nm, "_err_timeout"}, int'(eto), e_to);
        chk({nm, "_done_pulses"}, n_done - b_done, 1);
        chk({nm, "_busy_after"}, int'(xbusy), 0);
    endtask

    // Reference: walk attempts in order, each either completing its block or consuming a retry
    function automatic void model(input int cnt, input logic [31:0] fm,
                                  output int e_rem, output int starts, output int e_crc);
        int blk = 0, r = 0, att = 0;
        e_crc = 0;
        while (blk < cnt) begin
            if (!fm[att]) begin blk++; r = 0; end
            else if (r < RMAX) r++;
            else begin att++; e_crc = 1; break; end
            att++;
        end
        e_rem = cnt - blk;
        starts = att;
    endfunction

    typedef struct {
        bit wr; bit rd; int cnt; logic [31:0] fm; bit poke;
        int e_rem; int e_wr; int e_rd; int e_crc;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3, 32'h0, 1'b0, 0, 3, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1, 32'h0, 1'b0, 0, 0, 1, 0};
        tbl[2] = '{1'b1, 1'b1, 2, 32'h0, 1'b1, 0, 2, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 0, 32'h0, 1'b0, 0, 0, 0, 0};
`ifdef SD_XFER_RETRY_EN
        tbl[3] = '{1'b1, 1'b0, 4, 32'h2, 1'b0, 0, 5, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 2, 32'h7, 1'b0, 2, 0, 3, 1};
`else
        tbl[3] = '{1'b1, 1'b0, 4, 32'h2, 1'b0, 3, 2, 0, 1};
        tbl[5] = '{1'b0, 1'b1, 2, 32'h7, 1'b0, 2, 0, 1, 1};
`endif
        rst_n = 1'b0; req_write = 1'b0; req_read = 1'b0; blk_count = '0;
        timeout_val = '0; tx_ready = 1'b1; rx_ready = 1'b1;
        tick(3);
        chk("rst_start_dat", int'(start_dat), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(xbusy), 0);
        chk("rst_done", int'(xdone), 0);
        chk("rst_err_crc", int'(ecrc), 0);
        chk("rst_err_to", int'(eto), 0);
        chk("rst_rem", int'(rem), 0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            h_lat = 2; h_ackd = 1; h_fail = tbl[i].fm;
            req(tbl[i].wr, tbl[i].rd, tbl[i].cnt);
            wait_done(tbl[i].poke, 1'b0);
            check_run($sformatf("vec%0d", i), tbl[i].e_rem, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_crc, 0);
        end
        chk("vec_ack_len", ack_len, 2);

        // Read held off by a full RX FIFO; long host ack release
        h_ackd = 5; h_fail = '0; rx_ready = 1'b0;
        req(1'b0, 1'b1, 1);
        tick(10);
        chk("rxwait_no_start", n_any - b_any, 0);
        chk("rxwait_busy", int'(xbusy), 1);
        rx_ready = 1'b1;
        wait_done(1'b0, 1'b0);
        check_run("rxwait", 0, 0, 1, 0, 0);
        chk("rxwait_ack_len", ack_len, 6);

        // Host never completes: abort after timeout_val cycles in XFER
        timeout_val = 16'd50; h_hang = 1'b1; h_ackd = 2;
        req(1'b1, 1'b0, 2);
        wait_done(1'b0, 1'b0);
        check_run("abort", 2, 1, 0, 0, 1);
        chk("abort_count", n_ab - b_ab, 1);
        chk("abort_delay", t_abort - t_start, 52);
        chk("abort_ack_len", ack_len, 3);
        h_hang = 1'b0; timeout_val = '0;

        // Host never leaves IDLE
        h_noresp = 1'b1;
        req(1'b0, 1'b1, 3);
        wait_done(1'b0, 1'b0);
        check_run("nobusy", 3, 0, 1, 0, 1);
        h_noresp = 1'b0;

        // Reset in the middle of a block, then a zero-count request
        h_lat = 40; h_ackd = 1;
        req(1'b1, 1'b0, 3);
        tick(8);
        chk("midrst_busy_before", int'(xbusy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(xbusy), 0);
        chk("midrst_start_dat", int'(start_dat), 0);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_rem", int'(rem), 0);
        tick(2);
        rst_n = 1'b1; h_lat = 2;
        tick(2);
        req(1'b1, 1'b0, 0);
        tick(1);
        chk("zero_done", n_done - b_done, 1);
        chk("zero_no_start", n_any - b_any, 0);
        chk("zero_busy_after", int'(xbusy), 0);

        for (int i = 0; i < 25; i++) begin
            int cnt, e_rem, st, e_crc;
            bit wr, rd;
            logic [31:0] fm;
            wr = 1'($urandom % 2);
            rd = wr ? 1'($urandom % 2) : 1'b1;
            cnt = $urandom_range(0, 5);
            for (int k = 0; k < 32; k++) fm[k] = ($urandom % 5) == 0;
            h_lat = $urandom_range(1, 8);
            h_ackd = $urandom_range(0, 3);
            h_fail = fm;
            model(cnt, fm, e_rem, st, e_crc);
            req(wr, rd, cnt);
            wait_done(1'b0, 1'b1);
            check_run($sformatf("rnd%0d", i), e_rem, wr ? st : 0, wr ? 0 : st, e_crc, 0);
        end
        chk("min_ack_gap_ok", int'(min_gap >= GAP + 1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
